// File: rtl/dmem_bytelane.sv
// dmem_bytelane: word-organised data memory with per-byte lane enables for
// RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW, little-endian, valid/ready request and
// response handshake with a single registered response stage.
// Optional feature macro: DMEM_PARITY_EN (per-lane even parity with a
// parity_inj test input; parity errors report fault_code 11 on loads).
module dmem_bytelane #(
    parameter int unsigned       DEPTH_WORDS = 4096,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [2:0]        funct3,
    input  logic [31:0]       wd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rd,
    output logic              fault,
    output logic [1:0]        fault_code
`ifdef DMEM_PARITY_EN
    ,
    input  logic              parity_inj
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned AX_W  = ADDR_W + 1;

    // Range bounds carry one extra bit so the top of the array never wraps.
    localparam logic [AX_W-1:0] BASE_X  = {1'b0, BASE_ADDR};
    localparam logic [AX_W-1:0] LIMIT_X = BASE_X + (AX_W'(DEPTH_WORDS) << 2);

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_ALIGN = 2'b01;
    localparam logic [1:0] FC_RANGE = 2'b10;
    localparam logic [1:0] FC_ILL   = 2'b11;

    typedef struct packed {
        logic [31:0] rd;
        logic        fault;
        logic [1:0]  code;
    } rsp_t;

    // Storage: lane k of each word holds byte address word*4+k.
    logic [3:0][7:0] mem [DEPTH_WORDS];
`ifdef DMEM_PARITY_EN
    logic [3:0]      par [DEPTH_WORDS];
`endif

    logic              rsp_valid_q;
    rsp_t              rsp_q;
    rsp_t              rsp_c;

    logic              accept_c;
    logic [AX_W-1:0]   a_x_c;
    logic              illegal_c;
    logic              oor_c;
    logic              misalign_c;
    logic              req_fault_c;
    logic [1:0]        req_code_c;
    logic [IDX_W-1:0]  idx_c;
    logic [3:0]        be_c;
    logic [3:0][7:0]   wdat_c;
    logic [3:0][7:0]   word_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic              sext_c;
    logic [31:0]       ld_c;
    logic              wr_en_c;
    logic              perr_c;

    // Handshake: a single response slot that passes through once drained.
    always_comb begin
        req_ready = rst_n && (!rsp_valid_q || rsp_ready);
        accept_c  = req_valid && req_ready;
    end

    // Fault classification with priority illegal > out-of-range > misaligned.
    always_comb begin
        a_x_c       = {1'b0, a};
        illegal_c   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        oor_c       = (a_x_c < BASE_X) || (a_x_c >= LIMIT_X);
        misalign_c  = ((funct3[1:0] == 2'b01) && a[0]) ||
                      ((funct3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        req_fault_c = illegal_c || oor_c || misalign_c;
        if (illegal_c) begin
            req_code_c = FC_ILL;
        end else if (oor_c) begin
            req_code_c = FC_RANGE;
        end else if (misalign_c) begin
            req_code_c = FC_ALIGN;
        end else begin
            req_code_c = FC_NONE;
        end
    end

    // Word index relative to the base; base alignment keeps low bits exact.
    always_comb begin
        idx_c = a[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
    end

    // Lane enables and replicated store data for the access size.
    always_comb begin
        be_c   = 4'b1111;
        wdat_c = wd;
        case (funct3[1:0])
            2'b00: begin
                be_c   = 4'b0001 << a[1:0];
                wdat_c = {4{wd[7:0]}};
            end
            2'b01: begin
                be_c   = a[1] ? 4'b1100 : 4'b0011;
                wdat_c = {2{wd[15:0]}};
            end
            default: begin
                be_c   = 4'b1111;
                wdat_c = wd;
            end
        endcase
    end

    // Load path: select lanes, shift down and extend.
    always_comb begin
        word_c = mem[idx_c];
        byte_c = word_c[a[1:0]];
        half_c = a[1] ? {word_c[3], word_c[2]} : {word_c[1], word_c[0]};
        sext_c = !funct3[2];
        case (funct3[1:0])
            2'b00:   ld_c = {{24{sext_c & byte_c[7]}}, byte_c};
            2'b01:   ld_c = {{16{sext_c & half_c[15]}}, half_c};
            default: ld_c = word_c;
        endcase
    end

    // Parity check of the lanes a load actually selects.
    always_comb begin
        perr_c = 1'b0;
`ifdef DMEM_PARITY_EN
        for (int k = 0; k < 4; k++) begin
            if (be_c[k] && (par[idx_c][k] != ^word_c[k])) begin
                perr_c = 1'b1;
            end
        end
`endif
    end

    // Response payload for the request being accepted this cycle.
    always_comb begin
        rsp_c.rd    = 32'h0;
        rsp_c.fault = 1'b0;
        rsp_c.code  = FC_NONE;
        if (req_fault_c) begin
            rsp_c.fault = 1'b1;
            rsp_c.code  = req_code_c;
        end else if (!we) begin
            rsp_c.rd = ld_c;
            if (perr_c) begin
                rsp_c.fault = 1'b1;
                rsp_c.code  = FC_ILL;
            end
        end
    end

    // Only clean, accepted stores modify the array.
    always_comb begin
        wr_en_c = accept_c && we && !req_fault_c;
    end

    // Byte-lane write on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int k = 0; k < 4; k++) begin
                if (be_c[k]) begin
                    mem[idx_c][k] <= wdat_c[k];
`ifdef DMEM_PARITY_EN
                    par[idx_c][k] <= (^wdat_c[k]) ^ parity_inj;
`endif
                end
            end
        end
    end

    // Response register: load on accept, hold while stalled, clear on drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (accept_c) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= rsp_c;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Outputs come straight from the response register.
    always_comb begin
        rsp_valid  = rsp_valid_q;
        rd         = rsp_q.rd;
        fault      = rsp_q.fault;
        fault_code = rsp_q.code;
    end

endmodule
